// File: rtl/fpu_pkg.sv
// Shared types and format helpers for the FPU datapath blocks.
// Format helpers return 64-bit words; callers size-cast to their own 1+EXP_W+MAN_W width.
package fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } rm_e;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SPECIAL,
    ST_NORM_IN,
    ST_MULT,
    ST_NORM_OUT,
    ST_ROUND,
    ST_PACK,
    ST_OUT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } cls_e;

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fpu_exp_ones(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [63:0] fpu_qnan(input int exp_w, input int man_w);
    return fpu_exp_ones(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fpu_inf(input logic sign, input int exp_w, input int man_w);
    return ({63'd0, sign} << (exp_w + man_w)) | fpu_exp_ones(exp_w, man_w);
  endfunction

  function automatic logic [63:0] fpu_max_finite(input logic sign, input int exp_w, input int man_w);
    return ({63'd0, sign} << (exp_w + man_w))
         | (((64'd1 << exp_w) - 64'd2) << man_w)
         | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fpu_round.sv
// Combinational IEEE rounder: significand plus guard/round/sticky -> rounded significand.
// On carry-out the significand is returned already renormalised to 1.000...0.
module fpu_round
  import fpu_pkg::*;
#(
  parameter int SIG_W = 24
) (
  input  logic [SIG_W-1:0] i_sig,
  input  logic             i_guard,
  input  logic             i_round,
  input  logic             i_sticky,
  input  logic             i_sign,
  input  rm_e              i_rm,
  output logic [SIG_W-1:0] o_sig,
  output logic             o_carry,
  output logic             o_inexact
);

  logic             w_inc;
  logic [SIG_W:0]   w_sum;

  always_comb begin
    o_inexact = i_guard | i_round | i_sticky;
    w_inc     = 1'b0;
    unique case (i_rm)
      RM_RNE: w_inc = i_guard & (i_round | i_sticky | i_sig[0]);
      RM_RTZ: w_inc = 1'b0;
      RM_RUP: w_inc = ~i_sign & o_inexact;
      RM_RDN: w_inc = i_sign & o_inexact;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_sum   = {1'b0, i_sig} + {{SIG_W{1'b0}}, w_inc};
  assign o_carry = w_sum[SIG_W];
  // After a carry the sum is exactly 10...0, so its top SIG_W bits are the renormalised value.
  assign o_sig   = o_carry ? w_sum[SIG_W:1] : w_sum[SIG_W-1:0];

endmodule

// File: rtl/fpu_mul_seq.sv
// Multi-cycle IEEE-754 multiplier with valid/ready handshakes, four rounding modes, per-op flags.
// FPU_MUL_SUBNORMAL_EN enables gradual underflow; without it denormals read as zero and tiny results flush.
module fpu_mul_seq
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic [3:0]   out_flags
);

  localparam int SIG_W = MAN_W + 1;
  localparam int P_W   = 2 * SIG_W;
  localparam int E_W   = EXP_W + 2;
  localparam int BIAS  = fpu_bias(EXP_W);
  localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MIN  = E_W'(1 - BIAS);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);

  state_e                r_state, w_state_next;
  logic [W-1:0]          r_op [2];
  rm_e                   r_rm;
  cls_e                  w_cls [2];
  cls_e                  r_cls [2];
  logic signed [E_W-1:0] w_e [2];
  logic signed [E_W-1:0] r_e [2];
  logic [SIG_W-1:0]      w_m [2];
  logic [SIG_W-1:0]      r_m [2];
  logic                  r_zs;
  logic signed [E_W-1:0] r_ze;
  logic [P_W-1:0]        r_p;
  logic                  r_st;
  logic                  r_tiny;
  logic [SIG_W-1:0]      r_sig;
  logic                  r_nx;
  logic [W-1:0]          r_z;
  logic [3:0]            r_flags;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    logic [EXP_W-1:0] w_ef;
    logic [MAN_W-1:0] w_mf;
    assign w_ef = r_op[gi][W-2 -: EXP_W];
    assign w_mf = r_op[gi][MAN_W-1:0];
`ifdef FPU_MUL_SUBNORMAL_EN
    assign w_cls[gi] = (w_ef == '1) ? ((w_mf == '0) ? CLS_INF : (w_mf[MAN_W-1] ? CLS_QNAN : CLS_SNAN))
                     : (w_ef == '0) ? ((w_mf == '0) ? CLS_ZERO : CLS_SUB) : CLS_NORM;
`else
    assign w_cls[gi] = (w_ef == '1) ? ((w_mf == '0) ? CLS_INF : (w_mf[MAN_W-1] ? CLS_QNAN : CLS_SNAN))
                     : (w_ef == '0) ? CLS_ZERO : CLS_NORM;
`endif
    assign w_e[gi] = (w_ef == '0) ? E_MIN : $signed({2'b00, w_ef}) - E_BIAS;
    assign w_m[gi] = {(w_ef != '0), w_mf};
  end

  logic w_is_special, w_norm_done;
  assign w_is_special = !(w_cls[0] inside {CLS_NORM, CLS_SUB}) || !(w_cls[1] inside {CLS_NORM, CLS_SUB});
  // The shift in flight this cycle finishes normalisation when the bit below a zero MSB is set.
  assign w_norm_done  = (r_m[0][SIG_W-1] | r_m[0][SIG_W-2]) & (r_m[1][SIG_W-1] | r_m[1][SIG_W-2]);
`ifdef FPU_MUL_SUBNORMAL_EN
  logic w_needs_norm;
  assign w_needs_norm = !w_m[0][SIG_W-1] || !w_m[1][SIG_W-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (in_valid) w_state_next = ST_UNPACK;
      ST_UNPACK: begin
        if (w_is_special)      w_state_next = ST_SPECIAL;
`ifdef FPU_MUL_SUBNORMAL_EN
        else if (w_needs_norm) w_state_next = ST_NORM_IN;
`endif
        else                   w_state_next = ST_MULT;
      end
      ST_SPECIAL:  w_state_next = ST_OUT;
      ST_NORM_IN:  if (w_norm_done) w_state_next = ST_MULT;
      ST_MULT:     w_state_next = ST_NORM_OUT;
      ST_NORM_OUT: w_state_next = ST_ROUND;
      ST_ROUND:    w_state_next = ST_PACK;
      ST_PACK:     w_state_next = ST_OUT;
      ST_OUT:      if (out_ready) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_OUT);
  end

  assign out_z     = r_z;
  assign out_flags = r_flags;

  logic          w_any_nan, w_any_snan, w_any_inf, w_inf_zero;
  logic [W-1:0]  w_spec_z;
  logic [3:0]    w_spec_flags;
  assign w_any_nan  = (r_cls[0] inside {CLS_QNAN, CLS_SNAN}) || (r_cls[1] inside {CLS_QNAN, CLS_SNAN});
  assign w_any_snan = (r_cls[0] == CLS_SNAN) || (r_cls[1] == CLS_SNAN);
  assign w_any_inf  = (r_cls[0] == CLS_INF) || (r_cls[1] == CLS_INF);
  assign w_inf_zero = (r_cls[0] == CLS_INF && r_cls[1] == CLS_ZERO) || (r_cls[0] == CLS_ZERO && r_cls[1] == CLS_INF);

  always_comb begin
    w_spec_z     = {r_zs, {(W-1){1'b0}}};
    w_spec_flags = '0;
    if (w_any_nan || w_inf_zero) begin
      w_spec_z              = W'(fpu_qnan(EXP_W, MAN_W));
      w_spec_flags[FLAG_NV] = w_any_snan || w_inf_zero;
    end else if (w_any_inf) begin
      w_spec_z = W'(fpu_inf(r_zs, EXP_W, MAN_W));
    end
  end

  // Product normalisation: leading one is moved to the top bit so the field slices below are fixed.
  logic [P_W-1:0]        w_p1, w_p_sh;
  logic signed [E_W-1:0] w_e1, w_ze_n;
  logic                  w_tiny, w_st_n;
  assign w_p1   = r_p[P_W-1] ? r_p : (r_p << 1);
  assign w_e1   = r_p[P_W-1] ? r_ze + E_ONE : r_ze;
  assign w_tiny = (w_e1 < E_MIN);

`ifdef FPU_MUL_SUBNORMAL_EN
  localparam logic signed [E_W-1:0] E_SH_MAX = E_W'(MAN_W + 3);
  logic signed [E_W-1:0] w_sh;
  always_comb begin
    w_sh = '0;
    if (w_tiny) w_sh = ((E_MIN - w_e1) > E_SH_MAX) ? E_SH_MAX : (E_MIN - w_e1);
  end
  assign w_p_sh = w_p1 >> $unsigned(w_sh);
  assign w_st_n = |(w_p1 & ~({P_W{1'b1}} << $unsigned(w_sh)));
  assign w_ze_n = w_tiny ? E_MIN : w_e1;
`else
  assign w_p_sh = w_p1;
  assign w_st_n = 1'b0;
  assign w_ze_n = w_e1;
`endif

  logic [SIG_W-1:0] w_sig_rnd;
  logic             w_carry, w_nx;

  fpu_round #(.SIG_W(SIG_W)) u_round (
    .i_sig     (r_p[P_W-1 -: SIG_W]),
    .i_guard   (r_p[MAN_W]),
    .i_round   (r_p[MAN_W-1]),
    .i_sticky  (r_st || (|r_p[MAN_W-2:0])),
    .i_sign    (r_zs),
    .i_rm      (r_rm),
    .o_sig     (w_sig_rnd),
    .o_carry   (w_carry),
    .o_inexact (w_nx)
  );

  logic             w_ovf, w_use_inf;
  logic [EXP_W-1:0] w_exp_out;
  logic [W-1:0]     w_pack_z;
  logic [3:0]       w_pack_flags;
  assign w_ovf     = (r_ze > E_BIAS);
  assign w_use_inf = (r_rm == RM_RNE) || (r_rm == RM_RUP && !r_zs) || (r_rm == RM_RDN && r_zs);
  assign w_exp_out = r_sig[MAN_W] ? EXP_W'(r_ze + E_BIAS) : '0;

  always_comb begin
    w_pack_z              = {r_zs, w_exp_out, r_sig[MAN_W-1:0]};
    w_pack_flags          = '0;
    w_pack_flags[FLAG_NX] = r_nx;
    w_pack_flags[FLAG_UF] = r_tiny && r_nx;
    if (w_ovf) begin
      w_pack_z              = w_use_inf ? W'(fpu_inf(r_zs, EXP_W, MAN_W)) : W'(fpu_max_finite(r_zs, EXP_W, MAN_W));
      w_pack_flags          = '0;
      w_pack_flags[FLAG_OF] = 1'b1;
      w_pack_flags[FLAG_NX] = 1'b1;
    end
`ifndef FPU_MUL_SUBNORMAL_EN
    else if (r_tiny) begin
      w_pack_z              = {r_zs, {(W-1){1'b0}}};
      w_pack_flags          = '0;
      w_pack_flags[FLAG_UF] = 1'b1;
      w_pack_flags[FLAG_NX] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    unique case (r_state)
      ST_IDLE: if (in_valid) begin
        r_op[0] <= in_a;
        r_op[1] <= in_b;
        r_rm    <= rm_e'(in_rm);
      end
      ST_UNPACK: begin
        for (int i = 0; i < 2; i++) begin
          r_cls[i] <= w_cls[i];
          r_e[i]   <= w_e[i];
          r_m[i]   <= w_m[i];
        end
        r_zs <= r_op[0][W-1] ^ r_op[1][W-1];
      end
      ST_NORM_IN: begin
        for (int i = 0; i < 2; i++) begin
          if (!r_m[i][SIG_W-1]) begin
            r_m[i] <= r_m[i] << 1;
            r_e[i] <= r_e[i] - E_ONE;
          end
        end
      end
      ST_MULT: begin
        r_p  <= P_W'(r_m[0]) * P_W'(r_m[1]);
        r_ze <= r_e[0] + r_e[1];
      end
      ST_NORM_OUT: begin
        r_p    <= w_p_sh;
        r_st   <= w_st_n;
        r_ze   <= w_ze_n;
        r_tiny <= w_tiny;
      end
      ST_ROUND: begin
        r_sig <= w_sig_rnd;
        r_nx  <= w_nx;
        if (w_carry) r_ze <= r_ze + E_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z     <= '0;
      r_flags <= '0;
    end else if (r_state == ST_SPECIAL) begin
      r_z     <= w_spec_z;
      r_flags <= w_spec_flags;
    end else if (r_state == ST_PACK) begin
      r_z     <= w_pack_z;
      r_flags <= w_pack_flags;
    end
  end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Scoreboard bench for fpu_mul_seq (binary32): directed vectors, decoupled driver and monitor.
// Expectations for subnormal vectors follow FPU_MUL_SUBNORMAL_EN.
module tb_fpu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [3:0]  out_flags;

  fpu_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    string       name;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 1'b0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  // Monitor: latency on first out_valid, result and flags on the handshake edge.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got out_z 0x%h with empty scoreboard", out_z);
        end else begin
          check({sb_q[0].name, "_latency"}, 64'(cyc - acc_cyc), 64'(sb_q[0].lat));
        end
      end
      if (out_ready) begin
        if (sb_q.size() != 0) begin
          cur = sb_q.pop_front();
          check({cur.name, "_z"}, 64'(out_z), 64'(cur.z));
          check({cur.name, "_flags"}, 64'(out_flags), 64'(cur.f));
          $display("txn %-12s z=%h flags=%b (expected z=%h flags=%b)", cur.name, out_z, out_flags, cur.z, cur.f);
        end
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input logic [31:0] z, input logic [3:0] f, input int lat,
                       input string name, input bit push);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: in_ready=0, want 1", name);
      return;
    end
    if (push) sb_q.push_back('{z, f, lat, name});
    in_a     = a;
    in_b     = b;
    in_rm    = rm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_rm    = ~rm;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{32'hC1280000, 32'h40200000, 2'd0, 32'hC1D20000, 4'b0000, 5, "basic_rne"});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001, 5, "ulp_rne"});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'd1, 32'h3F800002, 4'b0001, 5, "ulp_rtz"});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001, 5, "ulp_rup"});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800002, 4'b0001, 5, "ulp_rdn"});
    vecs.push_back('{32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000, 2, "inf_x_zero"});
    vecs.push_back('{32'h7F800000, 32'hC0000000, 2'd0, 32'hFF800000, 4'b0000, 2, "inf_x_neg2"});
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b0000, 2, "qnan_in"});
    vecs.push_back('{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000, 2, "snan_in"});
    vecs.push_back('{32'h7F000000, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101, 5, "ovf_rne"});
    vecs.push_back('{32'h7F000000, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101, 5, "ovf_rtz"});
    vecs.push_back('{32'hFF000000, 32'h40000000, 2'd3, 32'hFF800000, 4'b0101, 5, "ovf_neg_rdn"});
    vecs.push_back('{32'hFF000000, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101, 5, "ovf_neg_rup"});
    vecs.push_back('{32'h80000000, 32'h40400000, 2'd0, 32'h80000000, 4'b0000, 2, "negzero_x3"});
`ifdef FPU_MUL_SUBNORMAL_EN
    vecs.push_back('{32'h00000001, 32'h3F800000, 2'd0, 32'h00000001, 4'b0000, 28, "sub_x_one"});
    vecs.push_back('{32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 4'b0000, 5, "tiny_result"});
`else
    vecs.push_back('{32'h00000001, 32'h3F800000, 2'd0, 32'h00000000, 4'b0000, 2, "sub_x_one"});
    vecs.push_back('{32'h00800000, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011, 5, "tiny_result"});
`endif

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_rm     = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_z", 64'(out_z), 64'd0);
    check("reset_out_flags", 64'(out_flags), 64'd0);
    rst = 1'b0;

    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].z, vecs[i].f, vecs[i].lat, vecs[i].name, 1'b1);
    wait_drain();

    // Back-pressure: result and in_ready must hold while the consumer stalls.
    out_ready = 1'b0;
    issue(32'hC1280000, 32'h40200000, 2'd0, 32'hC1D20000, 4'b0000, 5, "hold", 1'b1);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_out_z", 64'(out_z), 64'hC1D20000);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    wait_drain();

    // Abort in MULT: accept edge enters UNPACK, one more edge enters MULT.
    issue(32'h3F800001, 32'h3F800001, 2'd2, 32'h0, 4'b0, 0, "aborted", 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    issue(32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001, 5, "after_abort", 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
